// File: rtl/rand_pkg.sv
// rand_harvester shared types and helpers.
// FSM encoding and counter-width function.
package rand_pkg;

  typedef enum logic [1:0] {
    WARMUP,
    COLLECT,
    FULL
  } harvest_state_t;

  // $clog2 that never returns a zero width
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/repetition_count_test.sv
// Repetition-count health test on sampled bits.
// fail pulses on the strobe whose run hits REP_LIMIT.
module repetition_count_test
  import rand_pkg::*;
#(
  parameter int REP_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic bit_in,
  input  logic clear,
  output logic fail
);

  localparam int RW = clog2_min1(REP_LIMIT + 1);
  localparam logic [RW-1:0] RUN_PRE = RW'(REP_LIMIT - 1);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);

  logic [RW-1:0] run;
  logic          last_bit;
  logic          same;

  assign same = (bit_in == last_bit);

  // run reaching the limit on this strobe is a failure
  assign fail = strobe && same && (run == RUN_PRE);

  // track the current run of identical bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run      <= '0;
      last_bit <= 1'b0;
    end else begin
      if (strobe) begin
        last_bit <= bit_in;
      end
      // zero here so the next strobe restarts the run at 1
      if (clear) begin
        run <= '0;
      end else if (strobe) begin
        run <= same ? run + RUN_ONE : RUN_ONE;
      end
    end
  end

endmodule

// File: rtl/rand_harvester.sv
// Parity-reduces LHCA state into words on a valid/ready port.
// Warm-up, collection and a repetition-count health test.
module rand_harvester
  import rand_pkg::harvest_state_t;
  import rand_pkg::clog2_min1;
#(
  parameter int WIDTH     = 12,
  parameter int OUT_WIDTH = 32,
  parameter int DIVIDE    = 4,
  parameter int WARMUP    = 64,
  parameter int REP_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     state,
  // rand is a reserved word, hence rand_word
  output logic [OUT_WIDTH-1:0] rand_word,
  output logic                 valid,
  input  logic                 ready,
  output logic                 health_fail
);

  localparam int DW = clog2_min1(DIVIDE);
  localparam int WW = clog2_min1(WARMUP + 1);
  localparam int BW = clog2_min1(OUT_WIDTH + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIVIDE - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
  localparam logic [WW-1:0] WARM_ONE  = WW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(OUT_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  logic [DW-1:0]        div_cnt;
  logic [WW-1:0]        warm_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_next;
  harvest_state_t       fsm;

  logic strobe;
  logic b;
  logic slot_free;
  logic hc_strobe;
  logic hc_fail;

  assign strobe    = (div_cnt == DIV_LAST);
  assign b         = ^state;
  assign slot_free = !valid || ready;
  assign acc_next  = {acc[OUT_WIDTH-2:0], b};

  // health test is paused while a full word waits
  assign hc_strobe = strobe && (fsm != rand_pkg::FULL);

  repetition_count_test #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rct (
    .clk   (clk),
    .reset (reset),
    .strobe(hc_strobe),
    .bit_in(b),
    .clear (hc_fail),
    .fail  (hc_fail)
  );

  // free-running sample divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // sticky health failure flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      health_fail <= 1'b0;
    end else if (hc_fail) begin
      health_fail <= 1'b1;
    end
  end

  // warm-up / collect / full sequencing and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= rand_pkg::WARMUP;
      warm_cnt  <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      rand_word <= '0;
      valid     <= 1'b0;
    end else begin
      if (valid && ready) begin
        valid <= 1'b0;
      end
      unique case (fsm)
        rand_pkg::WARMUP: begin
          if (strobe) begin
            if (hc_fail) begin
              warm_cnt <= '0;
              bit_cnt  <= '0;
              acc      <= '0;
            end else if (warm_cnt == WARM_LAST) begin
              fsm      <= rand_pkg::COLLECT;
              warm_cnt <= '0;
              bit_cnt  <= '0;
              acc      <= '0;
            end else begin
              warm_cnt <= warm_cnt + WARM_ONE;
            end
          end
        end
        rand_pkg::COLLECT: begin
          if (strobe) begin
            if (hc_fail) begin
              fsm      <= rand_pkg::WARMUP;
              warm_cnt <= '0;
              bit_cnt  <= '0;
              acc      <= '0;
            end else if (bit_cnt == BIT_LAST) begin
              if (slot_free) begin
                rand_word <= acc_next;
                valid     <= 1'b1;
                bit_cnt   <= '0;
              end else begin
                acc <= acc_next;
                fsm <= rand_pkg::FULL;
              end
            end else begin
              acc     <= acc_next;
              bit_cnt <= bit_cnt + BIT_ONE;
            end
          end
        end
        rand_pkg::FULL: begin
          if (slot_free) begin
            rand_word <= acc;
            valid     <= 1'b1;
            bit_cnt   <= '0;
            fsm       <= rand_pkg::COLLECT;
          end
        end
        default: begin
          fsm <= rand_pkg::WARMUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_harvester.sv
// Bench for rand_harvester against a strobe-level model.
// Second instance exercises a failure on a word boundary.
module tb_rand_harvester;
  import rand_pkg::*;

  localparam int W  = 12;
  localparam int OW = 8;
  localparam int DV = 2;
  localparam int WU = 4;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic          ready3 = 1'b1;
  logic [W-1:0]  st = '0;
  logic [W-1:0]  st3 = '0;
  logic [OW-1:0] rw, rw3;
  logic          valid, valid3, hf, hf3;

  always #5 clk = ~clk;

  rand_harvester #(
    .WIDTH(W), .OUT_WIDTH(OW), .DIVIDE(DV),
    .WARMUP(WU), .REP_LIMIT(RL)
  ) dut (
    .clk(clk), .reset(reset), .state(st),
    .rand_word(rw), .valid(valid),
    .ready(ready), .health_fail(hf)
  );

  rand_harvester #(
    .WIDTH(W), .OUT_WIDTH(OW), .DIVIDE(DV),
    .WARMUP(WU), .REP_LIMIT(3)
  ) dut3 (
    .clk(clk), .reset(reset), .state(st3),
    .rand_word(rw3), .valid(valid3),
    .ready(ready3), .health_fail(hf3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model, in samples and words
  int            m_div, m_warm, m_run;
  bit            m_last, m_valid, m_hf, m_full;
  bit            m_bits[$];
  logic [OW-1:0] m_rand;
  int            edges;
  bit            alt_bit;

  bit seq3 [12] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 1, 1};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rpar(input bit p);
    logic [W-1:0] x;
    x = W'($urandom);
    x[0] = x[0] ^ (^x) ^ p;
    return x;
  endfunction

  function automatic logic [OW-1:0] pack();
    logic [OW-1:0] w;
    w = '0;
    foreach (m_bits[i]) w = (w << 1) | OW'(m_bits[i]);
    return w;
  endfunction

  task automatic model_reset();
    m_div = 0; m_warm = 0; m_run = 0;
    m_last = 0; m_valid = 0; m_hf = 0; m_full = 0;
    m_bits.delete();
    m_rand = '0;
    edges = 0;
    alt_bit = 1;
  endtask

  task automatic model_edge(input logic [W-1:0] s,
                            input bit rdy,
                            output bit strobed);
    bit b, slot, nv;
    b = ^s;
    slot = !m_valid || rdy;
    nv = m_valid && !rdy;
    strobed = (m_div == DV - 1);
    m_div = (m_div + 1) % DV;
    if (m_full) begin
      if (slot) begin
        m_rand = pack();
        nv = 1;
        m_bits.delete();
        m_full = 0;
      end
    end else if (strobed) begin
      if (b == m_last) m_run++;
      else m_run = 1;
      m_last = b;
      if (m_run >= RL) begin
        m_hf = 1;
        m_run = 0;
        m_warm = 0;
        m_bits.delete();
      end else if (m_warm < WU) begin
        m_warm++;
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == OW) begin
          if (slot) begin
            m_rand = pack();
            nv = 1;
            m_bits.delete();
          end else begin
            m_full = 1;
          end
        end
      end
    end
    m_valid = nv;
  endtask

  // inputs are set; advance one clock and compare
  task automatic step();
    bit sb;
    int e;
    e = edges + 1;
    if (e % 2 == 0 && e / 2 >= 1 && e / 2 <= 12)
      st3 = rpar(seq3[e/2-1]);
    else
      st3 = W'($urandom);
    model_edge(st, ready, sb);
    if (sb) alt_bit = ~alt_bit;
    @(posedge clk);
    edges++;
    @(negedge clk);
    check("rand", 32'(rw), 32'(m_rand));
    check("valid", 32'(valid), 32'(m_valid));
    check("health_fail", 32'(hf), 32'(m_hf));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    check("rst_rand", 32'(rw), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_hf", 32'(hf), 32'h0);
    model_reset();
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("init_valid", 32'(valid), 32'h0);
    check("init_hf", 32'(hf), 32'h0);
    reset = 1'b0;

    // some arbitrary activity, then reset mid-run
    for (int i = 0; i < 15; i++) begin
      st = W'($urandom);
      ready = 1'($urandom);
      step();
    end
    do_reset(2);

    // alternating bits, consumer always ready
    ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      st = rpar(alt_bit);
      step();
      if (edges == 1) check("b_no_strobe", 32'(valid), 32'h0);
      if (edges == 23) check("b_pre_valid", 32'(valid), 32'h0);
      if (edges == 24) begin
        check("b_first_valid", 32'(valid), 32'h1);
        check("b_first_word", 32'(rw), 32'hAA);
      end
      if (edges == 39) check("b_gap", 32'(valid), 32'h0);
      if (edges == 40) check("b_second", 32'(valid), 32'h1);
    end

    // consumer stalls; second word parks in FULL
    do_reset(1);
    ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      st = rpar(alt_bit);
      step();
      if (edges == 24) check("c_word", 32'(rw), 32'hAA);
      if (edges == 50) check("c_hold", 32'(valid), 32'h1);
    end
    ready = 1'b1;
    st = rpar(alt_bit);
    step();
    check("c_no_gap", 32'(valid), 32'h1);
    ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      st = rpar(alt_bit);
      step();
    end

    // stuck source, then recovery
    do_reset(2);
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      st = '0;
      step();
      if (edges == 7) check("d_pre_fail", 32'(hf), 32'h0);
      if (edges == 8) check("d_fail", 32'(hf), 32'h1);
    end
    for (int i = 0; i < 60; i++) begin
      st = rpar(alt_bit);
      step();
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) st = W'($urandom);
      else st = rpar(alt_bit);
      ready = ($urandom_range(0, 2) != 0);
      step();
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 3));
    end

    // failure on the word-completing strobe (REP_LIMIT=3)
    do_reset(2);
    ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      st = rpar(alt_bit);
      step();
      if (edges == 23) check("f_pre_fail", 32'(hf3), 32'h0);
      if (edges == 24) begin
        check("f_fail", 32'(hf3), 32'h1);
        check("f_no_word", 32'(valid3), 32'h0);
        check("f_fsm", 32'(dut3.fsm), 32'(rand_pkg::WARMUP));
      end
      if (edges == 30) check("f_still_none", 32'(valid3), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
